// File: rtl/customer_gate_decoder.sv
// Lobby entrance decoder: turns two photo-beam sensors into enter/leave steps
// for a downstream 3-bit up/down counter, with saturation at full and empty.
module customer_gate_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int MAX_COUNT       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic       switch,
    output logic       UporDown,
    output logic [2:0] occupancy,
    output logic       full,
    output logic       empty,
    output logic       reject,
    output logic       lost
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PCW = $clog2(PULSE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);
    localparam logic [2:0]     MAX_OCC    = 3'(MAX_COUNT);

    typedef enum logic [2:0] {
        IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLR
    } gate_state_t;

    typedef enum logic [2:0] {
        E_IDLE, E_SETUP, E_PULSE, E_HOLD, E_GAP
    } emit_state_t;

    // Bit 1 carries sensor_a (outer beam), bit 0 carries sensor_b (inner beam).
    logic [1:0]     sync1, sync2, filt;
    logic [DCW-1:0] deb_cnt [2];

    gate_state_t state, state_next;
    logic        enter_evt, exit_evt;

    emit_state_t    em_state, em_next;
    logic [PCW-1:0] pcnt, pcnt_next;
    logic           sw_next, ud_next;
    logic           pend_valid, pend_dir;

    logic evt, dir, blocked, ok, busy, pend_take, drop, store, start;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the debounce counter array is small and is reset
    // element by element like any other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {sensor_a, sensor_b};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        enter_evt  = 1'b0;
        exit_evt   = 1'b0;
        case (state)
            IDLE: case (filt)
                2'b10:   state_next = IN_A;
                2'b01:   state_next = OUT_B;
                2'b11:   state_next = WAIT_CLR;
                default: ;
            endcase
            IN_A: case (filt)
                2'b11:   state_next = IN_AB;
                2'b00:   state_next = IDLE;
                2'b01:   state_next = WAIT_CLR;
                default: ;
            endcase
            IN_AB: case (filt)
                2'b01:   state_next = IN_B;
                2'b10:   state_next = IN_A;
                2'b00:   state_next = IDLE;
                default: ;
            endcase
            IN_B: case (filt)
                2'b00:   begin state_next = IDLE; enter_evt = 1'b1; end
                2'b11:   state_next = IN_AB;
                2'b10:   state_next = WAIT_CLR;
                default: ;
            endcase
            OUT_B: case (filt)
                2'b11:   state_next = OUT_AB;
                2'b00:   state_next = IDLE;
                2'b10:   state_next = WAIT_CLR;
                default: ;
            endcase
            OUT_AB: case (filt)
                2'b10:   state_next = OUT_A;
                2'b01:   state_next = OUT_B;
                2'b00:   state_next = IDLE;
                default: ;
            endcase
            OUT_A: case (filt)
                2'b00:   begin state_next = IDLE; exit_evt = 1'b1; end
                2'b11:   state_next = OUT_AB;
                2'b01:   state_next = WAIT_CLR;
                default: ;
            endcase
            default: if (filt == 2'b00) state_next = IDLE;
        endcase
    end

    // Acceptance: an event that would overflow/underflow is rejected; one that
    // finds both the emitter and the pending slot busy is dropped.
    assign evt       = enter_evt | exit_evt;
    assign dir       = enter_evt;
    assign blocked   = (enter_evt && occupancy == MAX_OCC) || (exit_evt && occupancy == 3'd0);
    assign ok        = evt && !blocked;
    assign busy      = (em_state != E_IDLE) || pend_valid;
    assign pend_take = pend_valid && (em_state == E_IDLE || em_state == E_GAP);
    assign drop      = ok && busy && pend_valid && !pend_take;
    assign store     = ok && busy && !drop;
    assign start     = ok && !busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy  <= 3'd0;
            reject     <= 1'b0;
            lost       <= 1'b0;
            pend_valid <= 1'b0;
            pend_dir   <= 1'b0;
        end else begin
            reject <= evt && blocked;
            lost   <= drop;
            if (ok && !drop) occupancy <= dir ? occupancy + 3'd1 : occupancy - 3'd1;
            if (store) begin
                pend_valid <= 1'b1;
                pend_dir   <= dir;
            end else if (pend_take) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign full  = (occupancy == MAX_OCC);
    assign empty = (occupancy == 3'd0);

    // Emitter: SETUP settles UporDown a cycle ahead, HOLD keeps it a cycle after
    // switch falls, GAP guarantees the spacing before the next direction change.
    always_comb begin
        em_next   = em_state;
        pcnt_next = pcnt;
        ud_next   = UporDown;
        sw_next   = 1'b0;
        case (em_state)
            E_IDLE: begin
                if (pend_valid) begin
                    em_next = E_SETUP;
                    ud_next = pend_dir;
                end else if (start) begin
                    em_next = E_SETUP;
                    ud_next = dir;
                end
            end
            E_SETUP: begin
                em_next   = E_PULSE;
                sw_next   = 1'b1;
                pcnt_next = '0;
            end
            E_PULSE: begin
                if (pcnt == PULSE_LAST) begin
                    em_next = E_HOLD;
                end else begin
                    sw_next   = 1'b1;
                    pcnt_next = pcnt + 1'b1;
                end
            end
            E_HOLD: em_next = E_GAP;
            default: begin
                if (pend_valid) begin
                    em_next = E_SETUP;
                    ud_next = pend_dir;
                end else begin
                    em_next = E_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            em_state <= E_IDLE;
            pcnt     <= '0;
            switch   <= 1'b0;
            UporDown <= 1'b0;
        end else begin
            em_state <= em_next;
            pcnt     <= pcnt_next;
            switch   <= sw_next;
            UporDown <= ud_next;
        end
    end

endmodule
